// File: rtl/traffic_phase_ctrl_if.sv
// Phase controller bundle: run control, pedestrian button,
// countdown-timer handshake and display-facing light outputs.
interface traffic_phase_ctrl_if;
  logic       en;
  logic       ped_req;
  logic       timer_done;
  logic       timer_start;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    input  en,
    input  ped_req,
    input  timer_done,
    output timer_start,
    output light_ns,
    output light_ew,
    output walk,
    output ped_pending,
    output phase
  );

  modport slave (
    output en,
    output ped_req,
    output timer_done,
    input  timer_start,
    input  light_ns,
    input  light_ew,
    input  walk,
    input  ped_pending,
    input  phase
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with pedestrian walk phase,
// paced by expiries of an external countdown timer.
module traffic_phase_ctrl #(
  parameter int G_TICKS = 4,
  parameter int Y_TICKS = 1,
  parameter int R_TICKS = 1,
  parameter int W_TICKS = 3,
  parameter int TW      = 4
) (
  input  logic clk,
  input  logic rst,
  traffic_phase_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    RED_1 = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    RED_2 = 3'd6,
    WALK  = 3'd7
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t        state_q, state_n;
  logic [TW-1:0] cnt_q, cnt_n;
  logic          start_q, start_n;
  logic          ped_q, ped_n;
  logic          dir_q, dir_n;
  logic          expiry;

  function automatic logic [TW-1:0] load(input state_t s);
    logic [TW-1:0] v;
    v = '0;
    case (s)
      NS_G, EW_G:   v = TW'(G_TICKS - 1);
      NS_Y, EW_Y:   v = TW'(Y_TICKS - 1);
      RED_1, RED_2: v = TW'(R_TICKS - 1);
      WALK:         v = TW'(W_TICKS - 1);
      default:      v = '0;
    endcase
    return v;
  endfunction

  // done is stale while the restart pulse is in flight
  assign expiry = bus.timer_done && !start_q
               && bus.en && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      ped_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      start_q <= start_n;
      ped_q   <= ped_n;
      dir_q   <= dir_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    start_n = 1'b0;
    ped_n   = ped_q;
    dir_n   = dir_q;
    if (bus.ped_req && state_q != WALK)
      ped_n = 1'b1;
    if (state_q == IDLE) begin
      if (bus.en)
        state_n = NS_G;
    end else if (expiry) begin
      if (cnt_q != '0) begin
        cnt_n   = cnt_q - 1'b1;
        start_n = 1'b1;
      end else begin
        case (state_q)
          NS_G:  state_n = NS_Y;
          NS_Y:  state_n = RED_1;
          RED_1: state_n = ped_q ? WALK : EW_G;
          EW_G:  state_n = EW_Y;
          EW_Y:  state_n = RED_2;
          RED_2: state_n = ped_q ? WALK : NS_G;
          WALK:  state_n = dir_q ? NS_G : EW_G;
          default: state_n = IDLE;
        endcase
        if (state_n == WALK) begin
          dir_n = (state_q == RED_2);
          ped_n = 1'b0;
        end
      end
    end
    if (state_n != state_q) begin
      cnt_n   = load(state_n);
      start_n = 1'b1;
    end
  end

  always_comb begin
    bus.light_ns = RED;
    bus.light_ew = RED;
    bus.walk     = 1'b0;
    unique case (1'b1)
      state_q == NS_G: bus.light_ns = GRN;
      state_q == NS_Y: bus.light_ns = YEL;
      state_q == EW_G: bus.light_ew = GRN;
      state_q == EW_Y: bus.light_ew = YEL;
      state_q == WALK: bus.walk     = 1'b1;
      default: ;
    endcase
  end

  assign bus.timer_start = start_q;
  assign bus.ped_pending = ped_q;
  assign bus.phase       = state_q;

endmodule
